obf_insnseq: RTL and testbench
==============================

// Module: obf_insnseq
// PURPOSE
// - Drives ppc into obf_insngen and consumes its obf_insn/obf_last/obf_skip outputs.
// - Accepts one reference instruction from fetch and walks it through its substitution sequence.
// - Issues each resulting obfuscated instruction to decode through a registered valid/ready stage.
// - Sits between the IF stage and obf_insngen; stalls fetch while a sequence is in flight.
// PARAMETERS
// - PPC_MAX  default 2**`OBF_PPC_WIDTH-1  last legal ppc; reaching it without obf_last forces termination
// PORTS
// - clk           in   1                 clock
// - rst_n         in   1                 synchronous reset, active low
// - flush_i       in   1                 abort current sequence (branch/exception)
// - ref_valid_i   in   1                 reference instruction valid
// - ref_insn_i    in   32                reference instruction
// - ref_ready_o   out  1                 sequencer can accept ref_insn_i
// - gen_insn_o    out  32                held reference instruction to obf_insngen.ref_insn
// - gen_ppc_o     out  `OBF_PPC_WIDTH    pseudo-PC to obf_insngen.ppc_i
// - gen_insn_i    in   32                obf_insngen.obf_insn
// - gen_last_i    in   1                 obf_insngen.obf_last
// - gen_skip_i    in   1                 obf_insngen.obf_skip
// - out_valid_o   out  1                 obfuscated instruction valid to decode
// - out_insn_o    out  32                obfuscated instruction
// - out_last_o    out  1                 final instruction of the current sequence
// - out_ready_i   in   1                 decode accepts out_insn_o
// - seq_err_o     out  1                 one-cycle pulse: sequence forced closed at PPC_MAX
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE, gen_ppc_o=0, gen_insn_o=0, out_valid_o=0,
//   out_insn_o=0, out_last_o=0, seq_err_o=0. Reset overrides every other input.
// - FSM states: IDLE and RUN.
// - IDLE: ref_ready_o=1.
//   - On ref_valid_i: latch ref_insn_i into gen_insn_o, clear ppc, go to RUN.
// - RUN: ref_ready_o=0. Slot step when the output register is empty or drains this cycle
//   (out_valid_o=0 | out_ready_i).
// - On a step with gen_skip_i=0:
//   - Load out_insn_o<=gen_insn_i and out_last_o<=gen_last_i|(ppc==PPC_MAX); set out_valid_o=1.
// - On a step with gen_skip_i=1:
//   - Nothing is issued; out_valid_o clears if drained.
//   - If the slot is last, the sequence still closes.
// - After a step:
//   - Last slot (gen_last_i=1 or ppc==PPC_MAX): go to IDLE.
//   - Otherwise: ppc<=ppc+1, no wrap.
// - Forced close: ppc==PPC_MAX with gen_last_i=0 pulses seq_err_o for one cycle.
// - Output handshake:
//   - Transfer occurs when out_valid_o & out_ready_i.
//   - out_insn_o and out_last_o stay stable while out_valid_o=1 & out_ready_i=0.
// - Latency: ref accepted at edge N; first obfuscated insn is valid after edge N+1.
//   - Throughput is one insn/cycle with out_ready_i held high.
// - Skipped last slot: out_last_o is never raised for that sequence.
//   - Decode treats the IDLE return as sequence end.
// - flush_i (priority below reset, above all else):
//   - Next edge: state=IDLE, ppc=0, out_valid_o=0, seq_err_o=0.
//   - ref_valid_i is ignored in the flush cycle.
// - One-slot sequence (gen_last_i=1 at ppc 0): IDLE -> RUN -> IDLE.
//   - Exactly one insn issued, with out_last_o=1.
// CONFIGURATION
// - OBF_INSNSEQ_BYPASS_EN defined: adds input obf_en_i (1 bit, sampled in IDLE).
//   - With obf_en_i=0, an accepted ref_insn_i goes straight into the output register with
//     out_last_o=1; state stays IDLE and obf_insngen is not stepped.
//   - ref_ready_o=0 while the output register is full and not draining.
// - Macro undefined: no obf_en_i port; every instruction goes through RUN.
// TESTING
// - Reset: hold rst_n=0 for 2 cycles with ref_valid_i=1.
//   -> All outputs stay at reset values; ref_ready_o=1 after release.
// - 3-slot sequence, gen_last_i=1 at ppc=2, out_ready_i=1:
//   -> Three insns issued on consecutive cycles; out_last_o=1 only on the third; then IDLE.
// - Skip at ppc=1 of a 3-slot sequence:
//   -> Exactly 2 insns issued; ppc still reaches 2.
// - Backpressure: out_ready_i=0 for 4 cycles mid-sequence.
//   -> out_insn_o held stable; ppc frozen; resumes without loss.
// - Runaway: gen_last_i never set.
//   -> At ppc==PPC_MAX, out_last_o=1, seq_err_o pulses once, FSM returns to IDLE.
// - flush_i at ppc=1 with out_valid_o=1:
//   -> Next cycle out_valid_o=0, ppc=0, ref_ready_o=1; the held insn never transfers.

Source files
------------

// File: rtl/obf_insnseq.sv
// Sequencer between IF and obf_insngen: walks one reference instruction through its pseudo-PC
// slots and issues the obfuscated results to decode. Optional fetch bypass: OBF_INSNSEQ_BYPASS_EN.
`ifndef OBF_PPC_WIDTH
`define OBF_PPC_WIDTH 4
`endif

module obf_insnseq #(
  parameter int unsigned PPC_MAX = 2**`OBF_PPC_WIDTH-1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
`ifdef OBF_INSNSEQ_BYPASS_EN
  input  logic                      obf_en_i,
`endif
  input  logic                      ref_valid_i,
  input  logic [31:0]               ref_insn_i,
  output logic                      ref_ready_o,
  output logic [31:0]               gen_insn_o,
  output logic [`OBF_PPC_WIDTH-1:0] gen_ppc_o,
  input  logic [31:0]               gen_insn_i,
  input  logic                      gen_last_i,
  input  logic                      gen_skip_i,
  output logic                      out_valid_o,
  output logic [31:0]               out_insn_o,
  output logic                      out_last_o,
  input  logic                      out_ready_i,
  output logic                      seq_err_o
);

  localparam int PPC_W = `OBF_PPC_WIDTH;
  localparam logic [PPC_W-1:0] PPC_LAST = PPC_W'(PPC_MAX);
  localparam logic [PPC_W-1:0] PPC_ONE  = PPC_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, next_state;
  logic   accept;
  logic   bypass;
  logic   step;
  logic   last_slot;
  logic   forced_close;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // A slot advances only when the output register can take a new value this cycle.
  always_comb begin
    next_state   = state;
    ref_ready_o  = 1'b0;
    accept       = 1'b0;
    bypass       = 1'b0;
    step         = 1'b0;
    last_slot    = gen_last_i || (gen_ppc_o == PPC_LAST);
    forced_close = 1'b0;
    case (state)
      IDLE: begin
`ifdef OBF_INSNSEQ_BYPASS_EN
        ref_ready_o = !(out_valid_o && !out_ready_i);
`else
        ref_ready_o = 1'b1;
`endif
        accept = ref_valid_i && ref_ready_o && !flush_i;
        if (accept) begin
`ifdef OBF_INSNSEQ_BYPASS_EN
          if (obf_en_i)
            next_state = RUN;
          else
            bypass = 1'b1;
`else
          next_state = RUN;
`endif
        end
      end
      RUN: begin
        step = !out_valid_o || out_ready_i;
        if (step && last_slot) begin
          next_state   = IDLE;
          forced_close = !gen_last_i;
        end
      end
      default: next_state = IDLE;
    endcase
    if (flush_i)
      next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_insn_o  <= '0;
      gen_ppc_o   <= '0;
      out_valid_o <= 1'b0;
      out_insn_o  <= '0;
      out_last_o  <= 1'b0;
      seq_err_o   <= 1'b0;
    end else if (flush_i) begin
      gen_ppc_o   <= '0;
      out_valid_o <= 1'b0;
      seq_err_o   <= 1'b0;
    end else begin
      seq_err_o <= forced_close;
      if (out_valid_o && out_ready_i)
        out_valid_o <= 1'b0;
      if (accept) begin
        gen_insn_o <= ref_insn_i;
        gen_ppc_o  <= '0;
      end
      if (bypass) begin
        out_insn_o  <= ref_insn_i;
        out_last_o  <= 1'b1;
        out_valid_o <= 1'b1;
      end
      // Skipped slots issue nothing but still consume a ppc value or close the sequence.
      if (step) begin
        if (!gen_skip_i) begin
          out_insn_o  <= gen_insn_i;
          out_last_o  <= last_slot;
          out_valid_o <= 1'b1;
        end
        if (!last_slot)
          gen_ppc_o <= gen_ppc_o + PPC_ONE;
      end
    end
  end

endmodule

// File: tb/tb_obf_insnseq.sv
// Directed bench for obf_insnseq with a small obf_insngen stand-in: insn = ref ^ (0x11*(ppc+1)),
// last/skip asserted at programmable ppc values (-1 = never).
`ifndef OBF_PPC_WIDTH
`define OBF_PPC_WIDTH 4
`endif

module tb_obf_insnseq;

  localparam int PPC_W   = `OBF_PPC_WIDTH;
  localparam int PPC_MAX = 2**PPC_W-1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic             obf_en_i;
  logic             ref_valid_i;
  logic [31:0]      ref_insn_i;
  logic             ref_ready_o;
  logic [31:0]      gen_insn_o;
  logic [PPC_W-1:0] gen_ppc_o;
  logic [31:0]      gen_insn_i;
  logic             gen_last_i;
  logic             gen_skip_i;
  logic             out_valid_o;
  logic [31:0]      out_insn_o;
  logic             out_last_o;
  logic             out_ready_i;
  logic             seq_err_o;

  int checks = 0;
  int errors = 0;
  int last_at;
  int skip_at;

  always #5 clk = ~clk;

  assign gen_insn_i = gen_insn_o ^ (32'h11 * (32'(gen_ppc_o) + 32'd1));
  assign gen_last_i = (int'(gen_ppc_o) == last_at);
  assign gen_skip_i = (int'(gen_ppc_o) == skip_at);

  obf_insnseq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
`ifdef OBF_INSNSEQ_BYPASS_EN
    .obf_en_i    (obf_en_i),
`endif
    .ref_valid_i (ref_valid_i),
    .ref_insn_i  (ref_insn_i),
    .ref_ready_o (ref_ready_o),
    .gen_insn_o  (gen_insn_o),
    .gen_ppc_o   (gen_ppc_o),
    .gen_insn_i  (gen_insn_i),
    .gen_last_i  (gen_last_i),
    .gen_skip_i  (gen_skip_i),
    .out_valid_o (out_valid_o),
    .out_insn_o  (out_insn_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .seq_err_o   (seq_err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance one clock edge; returns at the following falling edge where outputs are stable.
  task automatic applyStimulus(input logic valid, input logic [31:0] insn);
    ref_valid_i = valid;
    ref_insn_i  = insn;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; obf_en_i = 1'b1; ref_valid_i = 1'b1;
    ref_insn_i = 32'hDEADBEEF; out_ready_i = 1'b1; last_at = -1; skip_at = -1;

    // Reset held with a pending request
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'hDEADBEEF);
      checkOutput("rst_valid", 32'(out_valid_o), 32'd0);
      checkOutput("rst_insn", out_insn_o, 32'd0);
      checkOutput("rst_last", 32'(out_last_o), 32'd0);
      checkOutput("rst_err", 32'(seq_err_o), 32'd0);
      checkOutput("rst_ppc", 32'(gen_ppc_o), 32'd0);
      checkOutput("rst_gen_insn", gen_insn_o, 32'd0);
    end
    ref_valid_i = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0);
    checkOutput("rst_ready", 32'(ref_ready_o), 32'd1);

    // Three-slot sequence at full throughput
    last_at = 2; skip_at = -1;
    applyStimulus(1'b1, 32'hA0000000);
    checkOutput("seq3_ready_run", 32'(ref_ready_o), 32'd0);
    checkOutput("seq3_gen_insn", gen_insn_o, 32'hA0000000);
    checkOutput("seq3_valid0", 32'(out_valid_o), 32'd0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("seq3_insn0", out_insn_o, 32'hA0000011);
    checkOutput("seq3_valid1", 32'(out_valid_o), 32'd1);
    checkOutput("seq3_last0", 32'(out_last_o), 32'd0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("seq3_insn1", out_insn_o, 32'hA0000022);
    checkOutput("seq3_last1", 32'(out_last_o), 32'd0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("seq3_insn2", out_insn_o, 32'hA0000033);
    checkOutput("seq3_last2", 32'(out_last_o), 32'd1);
    checkOutput("seq3_idle", 32'(ref_ready_o), 32'd1);
    applyStimulus(1'b0, 32'h0);
    checkOutput("seq3_drained", 32'(out_valid_o), 32'd0);

    // Skip at ppc 1
    last_at = 2; skip_at = 1;
    applyStimulus(1'b1, 32'hB0000000);
    applyStimulus(1'b0, 32'h0);
    checkOutput("skip_insn0", out_insn_o, 32'hB0000011);
    checkOutput("skip_ppc1", 32'(gen_ppc_o), 32'd1);
    applyStimulus(1'b0, 32'h0);
    checkOutput("skip_valid", 32'(out_valid_o), 32'd0);
    checkOutput("skip_ppc2", 32'(gen_ppc_o), 32'd2);
    applyStimulus(1'b0, 32'h0);
    checkOutput("skip_insn2", out_insn_o, 32'hB0000033);
    checkOutput("skip_valid2", 32'(out_valid_o), 32'd1);
    checkOutput("skip_last", 32'(out_last_o), 32'd1);
    checkOutput("skip_idle", 32'(ref_ready_o), 32'd1);
    applyStimulus(1'b0, 32'h0);

    // Backpressure for four cycles mid-sequence
    last_at = 3; skip_at = -1;
    applyStimulus(1'b1, 32'hC0000000);
    applyStimulus(1'b0, 32'h0);
    checkOutput("bp_insn0", out_insn_o, 32'hC0000011);
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0);
      checkOutput("bp_hold_insn", out_insn_o, 32'hC0000011);
      checkOutput("bp_hold_valid", 32'(out_valid_o), 32'd1);
      checkOutput("bp_hold_ppc", 32'(gen_ppc_o), 32'd1);
    end
    out_ready_i = 1'b1;
    applyStimulus(1'b0, 32'h0);
    checkOutput("bp_insn1", out_insn_o, 32'hC0000022);
    applyStimulus(1'b0, 32'h0);
    checkOutput("bp_insn2", out_insn_o, 32'hC0000033);
    applyStimulus(1'b0, 32'h0);
    checkOutput("bp_insn3", out_insn_o, 32'hC0000044);
    checkOutput("bp_last", 32'(out_last_o), 32'd1);
    applyStimulus(1'b0, 32'h0);

    // Runaway: generator never signals last
    last_at = -1; skip_at = -1;
    applyStimulus(1'b1, 32'hD0000000);
    for (int i = 0; i < PPC_MAX; i++) begin
      applyStimulus(1'b0, 32'h0);
      checkOutput("run_insn", out_insn_o, 32'hD0000000 ^ (32'h11 * 32'(i + 1)));
      checkOutput("run_last", 32'(out_last_o), 32'd0);
      checkOutput("run_err", 32'(seq_err_o), 32'd0);
    end
    applyStimulus(1'b0, 32'h0);
    checkOutput("run_final_insn", out_insn_o, 32'hD0000000 ^ (32'h11 * 32'(PPC_MAX + 1)));
    checkOutput("run_final_last", 32'(out_last_o), 32'd1);
    checkOutput("run_err_pulse", 32'(seq_err_o), 32'd1);
    checkOutput("run_idle", 32'(ref_ready_o), 32'd1);
    applyStimulus(1'b0, 32'h0);
    checkOutput("run_err_clear", 32'(seq_err_o), 32'd0);

    // Flush while an insn is held
    last_at = 3; skip_at = -1;
    applyStimulus(1'b1, 32'hE0000000);
    applyStimulus(1'b0, 32'h0);
    checkOutput("fl_valid_pre", 32'(out_valid_o), 32'd1);
    checkOutput("fl_ppc_pre", 32'(gen_ppc_o), 32'd1);
    out_ready_i = 1'b0;
    flush_i = 1'b1;
    applyStimulus(1'b1, 32'hF0000000);
    flush_i = 1'b0;
    checkOutput("fl_valid", 32'(out_valid_o), 32'd0);
    checkOutput("fl_ppc", 32'(gen_ppc_o), 32'd0);
    checkOutput("fl_ready", 32'(ref_ready_o), 32'd1);
    checkOutput("fl_ref_ignored", gen_insn_o, 32'hE0000000);
    out_ready_i = 1'b1;
    applyStimulus(1'b0, 32'h0);
    checkOutput("fl_stay_idle", 32'(ref_ready_o), 32'd1);
    checkOutput("fl_no_issue", 32'(out_valid_o), 32'd0);

    // One-slot sequence
    last_at = 0; skip_at = -1;
    applyStimulus(1'b1, 32'h12345678);
    checkOutput("one_run", 32'(ref_ready_o), 32'd0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("one_insn", out_insn_o, 32'h12345669);
    checkOutput("one_last", 32'(out_last_o), 32'd1);
    checkOutput("one_idle", 32'(ref_ready_o), 32'd1);
    checkOutput("one_err", 32'(seq_err_o), 32'd0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("one_drained", 32'(out_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
